// File: rtl/fpu_alt_wb_recv.sv
// ---------------------------------------------------------------------------
// fpu_alt_wb_recv
//
// Receiving end of the long-latency FP alternate writeback path used by the
// sqrt/div units. A result is announced with its tags (destination register,
// instruction index, opcode) on i_alt_en, and its data follows DATA_LAT cycles
// later on i_alt_data. The tags ride a DATA_LAT-deep shift register so they
// meet their data at the last stage. The completed result is queued in a
// small FIFO. The FIFO drains into the shared register-file write port in
// cycles the main FP pipe leaves free (i_wb_busy low).
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active high
//   i_except     pipeline flush: drop all in-flight and queued results
//   i_alt_en     one result announced this cycle
//   i_alt_reg    destination physical register of the announced result
//   i_alt_II     instruction index of the announced result
//   i_alt_op     opcode of the announced result
//   i_alt_data   result data, valid DATA_LAT cycles after its i_alt_en
//   i_wb_busy    main FP pipe owns the write port this cycle
//   o_alt_pause  credit back-pressure to the sqrt/div unit
//   o_wb_en      write port request
//   o_wb_reg     write register (9'h1ff when idle)
//   o_wb_II      instruction index for retire (0 when idle)
//   o_wb_op      opcode of written result (0 when idle)
//   o_wb_data    write data (0 when idle)
//   o_ret_en     completion pulse to retire logic, coincident with o_wb_en
// ---------------------------------------------------------------------------
module fpu_alt_wb_recv #(
  parameter bit  H          = 1'b0,
  parameter int  DATA_LAT   = 5,
  parameter int  FIFO_DEPTH = 4,
  localparam int DW         = (H ? 16 : 0) + 68
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_except,
  input  logic          i_alt_en,
  input  logic [8:0]    i_alt_reg,
  input  logic [9:0]    i_alt_II,
  input  logic [12:0]   i_alt_op,
  input  logic [DW-1:0] i_alt_data,
  input  logic          i_wb_busy,
  output logic          o_alt_pause,
  output logic          o_wb_en,
  output logic [8:0]    o_wb_reg,
  output logic [9:0]    o_wb_II,
  output logic [12:0]   o_wb_op,
  output logic [DW-1:0] o_wb_data,
  output logic          o_ret_en
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [8:0]    rg;
    logic [9:0]    ii;
    logic [12:0]   op;
    logic [DW-1:0] data;
  } result_t;

  // Tag pipe
  logic [DATA_LAT-1:0] r_tagValid;
  logic [8:0]          r_tagReg [DATA_LAT];
  logic [9:0]          r_tagII  [DATA_LAT];
  logic [12:0]         r_tagOp  [DATA_LAT];

  // Result FIFO
  result_t             r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wrPtr;
  logic [AW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;
  logic                r_ovf;

  // Registered write-port outputs
  logic                r_wbEn;
  logic [8:0]          r_wbReg;
  logic [9:0]          r_wbII;
  logic [12:0]         r_wbOp;
  logic [DW-1:0]       r_wbData;

  logic                w_lastValid;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_pushOk;
  logic                w_pushDrop;
  result_t             w_pushEntry;
  result_t             w_head;
  logic [15:0]         w_occupancy;

  // Valid bits of the tag pipe. Reset and flush both wipe every stage, which
  // also discards an announcement arriving in the flush cycle itself. Data
  // that later shows up for a wiped tag finds no valid bit and is ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_except) begin
      r_tagValid <= '0;
    end else begin
      r_tagValid[0] <= i_alt_en;
      for (int k = 1; k < DATA_LAT; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
      end
    end
  end

  // Tag payload travels alongside the valid bits. It is only meaningful where
  // the matching valid is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    r_tagReg[0] <= i_alt_reg;
    r_tagII[0]  <= i_alt_II;
    r_tagOp[0]  <= i_alt_op;
    for (int k = 1; k < DATA_LAT; k++) begin
      r_tagReg[k] <= r_tagReg[k-1];
      r_tagII[k]  <= r_tagII[k-1];
      r_tagOp[k]  <= r_tagOp[k-1];
    end
  end

  // A valid tag at the last stage is paired with the data presented this
  // cycle. A pop in the same cycle frees a slot, so a full FIFO that is also
  // draining still accepts the push; only a full, stalled FIFO drops it.
  assign w_lastValid = r_tagValid[DATA_LAT-1];
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && !i_wb_busy;
  assign w_pushOk    = w_lastValid && (!w_full || w_pop);
  assign w_pushDrop  = w_lastValid && w_full && !w_pop;
  assign w_pushEntry = {r_tagReg[DATA_LAT-1], r_tagII[DATA_LAT-1],
                        r_tagOp[DATA_LAT-1], i_alt_data};
  assign w_head      = r_mem[r_rdPtr];

  // FIFO storage. Writes during reset/flush are harmless because the
  // pointers and count are cleared on the same edge.
  always_ff @(posedge i_clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= w_pushEntry;
    end
  end

  // FIFO pointers and occupancy. Pointers are log2(depth) wide and wrap on
  // their own; the count has one extra bit to tell full from empty. The
  // overflow flag is sticky until reset so a dropped result is never lost
  // from view, even across a flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_except) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pushDrop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Write-port register. The head is presented the cycle after it is popped;
  // every other cycle the port shows the idle pattern (register 9'h1ff, all
  // other fields zero).
  always_ff @(posedge i_clk) begin
    if (i_rst || i_except || !w_pop) begin
      r_wbEn   <= 1'b0;
      r_wbReg  <= 9'h1ff;
      r_wbII   <= '0;
      r_wbOp   <= '0;
      r_wbData <= '0;
    end else begin
      r_wbEn   <= 1'b1;
      r_wbReg  <= w_head.rg;
      r_wbII   <= w_head.ii;
      r_wbOp   <= w_head.op;
      r_wbData <= w_head.data;
    end
  end

  // Credit check: every queued result plus every tag still in flight will
  // eventually need a FIFO slot. Pausing one slot early covers the result
  // the unit may announce in the same cycle it first sees the pause.
  always_comb begin
    w_occupancy = 16'(r_count);
    for (int k = 0; k < DATA_LAT; k++) begin
      w_occupancy = w_occupancy + 16'(r_tagValid[k]);
    end
  end

  assign o_alt_pause = (w_occupancy >= 16'(FIFO_DEPTH - 1));
  assign o_wb_en     = r_wbEn;
  assign o_ret_en    = r_wbEn;
  assign o_wb_reg    = r_wbReg;
  assign o_wb_II     = r_wbII;
  assign o_wb_op     = r_wbOp;
  assign o_wb_data   = r_wbData;

endmodule

// File: tb/tb_fpu_alt_wb_recv.sv
// ---------------------------------------------------------------------------
// tb_fpu_alt_wb_recv
//
// Self-checking bench for fpu_alt_wb_recv with default parameters
// (H=0, DATA_LAT=5, FIFO_DEPTH=4). A queue-based reference model tracks
// announced-but-not-yet-paired results, the queued results and the sticky
// overflow flag, and predicts the write port, the pause output and the
// overflow flag cycle by cycle. Each scenario task also pins the key
// cycle-exact values with constants.
// ---------------------------------------------------------------------------
module tb_fpu_alt_wb_recv;

  localparam int DATA_LAT   = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = 68;
  localparam int OW         = 1 + 1 + 9 + 10 + 13 + DW;
  localparam logic [OW-1:0] IDLE = {2'b00, 9'h1ff, 10'h000, 13'h0000, {DW{1'b0}}};

  logic          clk;
  logic          rst;
  logic          exc;
  logic          altEn;
  logic [8:0]    altReg;
  logic [9:0]    altII;
  logic [12:0]   altOp;
  logic [DW-1:0] altData;
  logic          wbBusy;
  logic          oAltPause;
  logic          oWbEn;
  logic [8:0]    oWbReg;
  logic [9:0]    oWbII;
  logic [12:0]   oWbOp;
  logic [DW-1:0] oWbData;
  logic          oRetEn;
  logic [OW-1:0] obsOut;

  assign obsOut = {oWbEn, oRetEn, oWbReg, oWbII, oWbOp, oWbData};

  fpu_alt_wb_recv dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_except    (exc),
    .i_alt_en    (altEn),
    .i_alt_reg   (altReg),
    .i_alt_II    (altII),
    .i_alt_op    (altOp),
    .i_alt_data  (altData),
    .i_wb_busy   (wbBusy),
    .o_alt_pause (oAltPause),
    .o_wb_en     (oWbEn),
    .o_wb_reg    (oWbReg),
    .o_wb_II     (oWbII),
    .o_wb_op     (oWbOp),
    .o_wb_data   (oWbData),
    .o_ret_en    (oRetEn)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int due; logic [8:0] rg; logic [9:0] ii; logic [12:0] op; } tag_t;
  typedef struct { logic [8:0] rg; logic [9:0] ii; logic [12:0] op; logic [DW-1:0] d; } res_t;
  typedef struct { int due; logic [DW-1:0] d; } dat_t;

  tag_t          pendQ[$];
  res_t          fifoQ[$];
  dat_t          dataQ[$];
  logic [OW-1:0] expNext = IDLE;
  logic [OW-1:0] expCur;
  logic          expPauseCur;
  logic          expOvf = 1'b0;
  logic          expOvfCur;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] rndData();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic modelPause();
    return (fifoQ.size() + pendQ.size()) >= FIFO_DEPTH - 1;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one cycle of stimulus, publish the expectations for the current
  // cycle, then advance the reference model across the coming edge. The data
  // bus carries a result's data exactly DATA_LAT cycles after its
  // announcement (even if a flush or reset cancelled it) and noise otherwise.
  task automatic applyStimulus(input logic en, input logic [8:0] rg, input logic [9:0] ii,
                               input logic [12:0] op, input logic [DW-1:0] d,
                               input logic busy, input logic ex, input logic rs);
    tag_t t;
    res_t r;
    dat_t dd;
    logic pop;
    logic havePush;
    rst    = rs;
    exc    = ex;
    wbBusy = busy;
    altEn  = en;
    altReg = rg;
    altII  = ii;
    altOp  = op;
    if (en) begin
      dd.due = cyc + DATA_LAT;
      dd.d   = d;
      dataQ.push_back(dd);
    end
    while (dataQ.size() > 0 && dataQ[0].due < cyc) void'(dataQ.pop_front());
    altData = (dataQ.size() > 0 && dataQ[0].due == cyc) ? dataQ[0].d : rndData();

    expCur      = expNext;
    expPauseCur = modelPause();
    expOvfCur   = expOvf;

    if (rs) begin
      pendQ.delete();
      fifoQ.delete();
      expNext = IDLE;
      expOvf  = 1'b0;
    end else if (ex) begin
      pendQ.delete();
      fifoQ.delete();
      expNext = IDLE;
    end else begin
      pop      = (fifoQ.size() > 0) && !busy;
      expNext  = pop ? {2'b11, fifoQ[0].rg, fifoQ[0].ii, fifoQ[0].op, fifoQ[0].d} : IDLE;
      havePush = (pendQ.size() > 0) && (pendQ[0].due == cyc);
      if (havePush) begin
        t    = pendQ.pop_front();
        r.rg = t.rg;
        r.ii = t.ii;
        r.op = t.op;
        r.d  = altData;
      end
      if (pop) void'(fifoQ.pop_front());
      if (havePush) begin
        if (fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(r);
        else expOvf = 1'b1;
      end
      if (en) begin
        t.due = cyc + DATA_LAT;
        t.rg  = rg;
        t.ii  = ii;
        t.op  = op;
        pendQ.push_back(t);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 9'h0, 10'h0, 13'h0, '0, 1'b0, 1'b0, k < 2);
      if (k >= 2) begin
        checks++;
        if (obsOut !== expCur) begin failures++; $display("[TB] FAIL reset_port cyc=%0d got=%h exp=%h", cyc, obsOut, expCur); end
        checks++;
        if (oWbEn !== 1'b0 || oRetEn !== 1'b0 || oWbReg !== 9'h1ff || oWbII !== 10'h0 || oWbOp !== 13'h0 || oWbData !== 68'h0)
          begin failures++; $display("[TB] FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obsOut, IDLE); end
        checks++;
        if (oAltPause !== 1'b0 || dut.r_ovf !== 1'b0)
          begin failures++; $display("[TB] FAIL reset_flags cyc=%0d pause=%b ovf=%b exp 0/0", cyc, oAltPause, dut.r_ovf); end
      end
      tick();
    end
  endtask

  task automatic test_single_op();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k == 0, 9'h021, 10'h005, 13'h0abc, 68'h3FF0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL single_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (oAltPause !== expPauseCur) begin failures++; $display("[TB] FAIL single_pause k=%0d got=%b exp=%b", k, oAltPause, expPauseCur); end
      checks++;
      if (oWbEn !== (k == 7)) begin failures++; $display("[TB] FAIL single_wb_en k=%0d got=%b exp=%b", k, oWbEn, (k == 7)); end
      if (k == 7) begin
        checks++;
        if (oRetEn !== 1'b1 || oWbReg !== 9'h021 || oWbII !== 10'h005 || oWbOp !== 13'h0abc || oWbData !== 68'h3FF0)
          begin failures++; $display("[TB] FAIL single_fields got=%h exp reg=021 II=005 data=3ff0", obsOut); end
      end
      tick();
    end
  endtask

  task automatic test_burst();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k < 3, 9'(9'h040 + k), 10'(k + 1), 13'($urandom), rndData(),
                    (k >= 5 && k <= 12), 1'b0, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL burst_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (oAltPause !== expPauseCur) begin failures++; $display("[TB] FAIL burst_pause k=%0d got=%b exp=%b", k, oAltPause, expPauseCur); end
      if (k == 2 || k == 3 || k == 13 || k == 14) begin
        checks++;
        if (oAltPause !== (k == 3 || k == 13)) begin failures++; $display("[TB] FAIL burst_pause_edge k=%0d got=%b exp=%b", k, oAltPause, (k == 3 || k == 13)); end
      end
      if (k >= 13 && k <= 17) begin
        checks++;
        if (oWbEn !== (k >= 14 && k <= 16) || (oWbEn === 1'b1 && oWbII !== 10'(k - 13)))
          begin failures++; $display("[TB] FAIL burst_order k=%0d wb_en=%b II=%0d exp_II=%0d", k, oWbEn, oWbII, k - 13); end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic busy;
    for (int k = 0; k < 16; k++) begin
      busy = (k <= 8) || (k == 10);
      applyStimulus(k < 2, 9'h0aa, 10'(16 + k), 13'h1234, rndData(), busy, 1'b0, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL contend_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (oAltPause !== expPauseCur) begin failures++; $display("[TB] FAIL contend_pause k=%0d got=%b exp=%b", k, oAltPause, expPauseCur); end
      if (k >= 9 && k <= 13) begin
        checks++;
        if (oWbEn !== (k == 10 || k == 12) || (oWbEn === 1'b1 && oWbII !== (k == 10 ? 10'd16 : 10'd17)))
          begin failures++; $display("[TB] FAIL contend_slot k=%0d wb_en=%b II=%0d", k, oWbEn, oWbII); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k < 2, 9'h077, 10'(32 + k), 13'h0fff, rndData(), 1'b0, k == 3, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL flush_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (oWbEn !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_write k=%0d got=%b exp=0", k, oWbEn); end
      if (k == 4) begin
        checks++;
        if (oAltPause !== 1'b0) begin failures++; $display("[TB] FAIL flush_pause k=4 got=%b exp=0", oAltPause); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 24; k++) begin
      if (k < 12) applyStimulus(k < 3, 9'h055, 10'(48 + k), 13'h0111, rndData(), k <= 9, 1'b0, k == 9);
      else        applyStimulus(k == 12, 9'h021, 10'h005, 13'h0abc, 68'h3FF0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL rstmid_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (oAltPause !== expPauseCur) begin failures++; $display("[TB] FAIL rstmid_pause k=%0d got=%b exp=%b", k, oAltPause, expPauseCur); end
      if (k == 10) begin
        checks++;
        if (oWbEn !== 1'b0 || oWbReg !== 9'h1ff || oWbData !== 68'h0 || oAltPause !== 1'b0)
          begin failures++; $display("[TB] FAIL rstmid_idle got=%h pause=%b exp=%h pause=0", obsOut, oAltPause, IDLE); end
      end
      if (k >= 13) begin
        checks++;
        if (oWbEn !== (k == 19) || (k == 19 && (oWbReg !== 9'h021 || oWbII !== 10'h005 || oWbData !== 68'h3FF0)))
          begin failures++; $display("[TB] FAIL rstmid_after k=%0d got=%h", k, obsOut); end
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k < 5, 9'h0f0, 10'(k + 1), 13'h0222, rndData(), k <= 12, 1'b0, 1'b0);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL ovf_port k=%0d got=%h exp=%h", k, obsOut, expCur); end
      checks++;
      if (dut.r_ovf !== expOvfCur) begin failures++; $display("[TB] FAIL ovf_flag k=%0d got=%b exp=%b", k, dut.r_ovf, expOvfCur); end
      if (k == 9 || k == 10) begin
        checks++;
        if (dut.r_ovf !== (k == 10)) begin failures++; $display("[TB] FAIL ovf_edge k=%0d got=%b exp=%b", k, dut.r_ovf, (k == 10)); end
      end
      if (k >= 13 && k <= 18) begin
        checks++;
        if (oWbEn !== (k >= 14 && k <= 17) || (oWbEn === 1'b1 && oWbII !== 10'(k - 13)))
          begin failures++; $display("[TB] FAIL ovf_order k=%0d wb_en=%b II=%0d exp_II=%0d", k, oWbEn, oWbII, k - 13); end
      end
      tick();
    end
  endtask

  // Random traffic: the unit mostly honours the pause, occasionally ignores
  // it, with random port contention and rare flushes and resets, followed by
  // an idle tail so every queued result drains.
  task automatic test_random();
    logic en;
    logic busy;
    logic ex;
    logic rs;
    for (int k = 0; k < 630; k++) begin
      if (k < 600) begin
        en   = ($urandom_range(0, 1) == 1) && (!modelPause() || $urandom_range(0, 7) == 0);
        busy = ($urandom_range(0, 2) == 0);
        ex   = ($urandom_range(0, 63) == 0);
        rs   = ($urandom_range(0, 127) == 0);
      end else begin
        en   = 1'b0;
        busy = 1'b0;
        ex   = 1'b0;
        rs   = 1'b0;
      end
      applyStimulus(en, 9'($urandom), 10'($urandom), 13'($urandom), rndData(), busy, ex, rs);
      checks++;
      if (obsOut !== expCur) begin failures++; $display("[TB] FAIL random_port cyc=%0d got=%h exp=%h", cyc, obsOut, expCur); end
      checks++;
      if (oAltPause !== expPauseCur) begin failures++; $display("[TB] FAIL random_pause cyc=%0d got=%b exp=%b", cyc, oAltPause, expPauseCur); end
      checks++;
      if (dut.r_ovf !== expOvfCur) begin failures++; $display("[TB] FAIL random_ovf cyc=%0d got=%b exp=%b", cyc, dut.r_ovf, expOvfCur); end
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    exc     = 1'b0;
    altEn   = 1'b0;
    altReg  = '0;
    altII   = '0;
    altOp   = '0;
    altData = '0;
    wbBusy  = 1'b0;
    test_reset();
    test_single_op();
    test_burst();
    test_contention();
    test_flush();
    test_reset_midstream();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
